// File: rtl/motion_estimator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : motion_estimator_if                                           |
// | Purpose  : Bus between the motion estimator, the reference/search frame  |
// |            memories and the encoder control.                             |
// | Signals  : start                  run/hold request from encoder control  |
// |            R, S1, S2              pixel data returned by the memories    |
// |            AddressR/S1/S2         pixel addresses issued by the estimator|
// |            motionX, motionY       best displacement (two's complement)   |
// |            BestDist               best SAD saturated to 8 bits           |
// |            completed              search finished, result final          |
// | Modports : master = memories + encoder side, slave = estimator           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface motion_estimator_if;
  logic       start;
  logic [7:0] R;
  logic [7:0] S1;
  logic [7:0] S2;
  logic [7:0] AddressR;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic [3:0] motionX;
  logic [3:0] motionY;
  logic [7:0] BestDist;
  logic       completed;

  modport master (
    output start, R, S1, S2,
    input  AddressR, AddressS1, AddressS2, motionX, motionY, BestDist, completed
  );

  modport slave (
    input  start, R, S1, S2,
    output AddressR, AddressS1, AddressS2, motionX, motionY, BestDist, completed
  );
endinterface
`default_nettype wire

// File: rtl/motion_estimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : motion_estimator                                              |
// | Purpose  : Full-search block matcher. A 16x16 reference block is matched |
// |            against all 256 positions (dx,dy in -8..7) of a 32x32 search  |
// |            window with a 16-PE systolic array; the position of minimum   |
// |            SAD is reported.                                              |
// | Ports    : clock   rising-edge clock                                     |
// |            reset   synchronous, active-low                               |
// |            bus     motion_estimator_if.slave (start, pixels, addresses,  |
// |                    motionX/motionY/BestDist/completed)                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module motion_estimator (
  input wire logic          clock,
  input wire logic          reset,
  motion_estimator_if.slave bus
);

  localparam logic [12:0] c_count_done = 13'd4112;
  localparam logic [12:0] c_first_cmp  = 13'd256;
  localparam logic [12:0] c_last_cmp   = 13'd4111;

  logic        w_run;
  logic [12:0] r_count;
  logic [3:0]  w_vy;
  logic [3:0]  w_row;
  logic [3:0]  w_col;
  logic [4:0]  w_srow;
  logic [9:0]  w_sbase;

  // Everything in the datapath is held cleared unless a run is active, so
  // the registers are already zero on the count=0 cycle that opens a run.
  assign w_run = reset & bus.start;

  always_ff @(posedge clock) begin
    if (!w_run) begin
      r_count <= '0;
    end else if (r_count < c_count_done) begin
      r_count <= r_count + 13'd1;
    end
  end

  // Address generation: vy selects the window row offset, r/c walk the block.
  assign w_vy    = r_count[11:8];
  assign w_row   = r_count[7:4];
  assign w_col   = r_count[3:0];
  assign w_srow  = {1'b0, w_vy} + {1'b0, w_row};
  assign w_sbase = {w_srow, 5'd0} + {6'd0, w_col};

  assign bus.AddressR  = r_count[7:0];
  assign bus.AddressS1 = w_sbase;
  assign bus.AddressS2 = w_sbase + 10'd16;

  // R delay chain (tap k = sample issued k cycles ago) and a 16-deep S2
  // delay giving the right-half pixel of the previous block row.
  logic [7:0] r_rdly  [1:15];
  logic [7:0] r_s2dly [0:15];

  always_ff @(posedge clock) begin
    if (!w_run) begin
      for (int i = 1; i < 16; i++) r_rdly[i] <= '0;
      for (int i = 0; i < 16; i++) r_s2dly[i] <= '0;
    end else begin
      r_rdly[1] <= bus.R;
      for (int i = 2; i < 16; i++) r_rdly[i] <= r_rdly[i-1];
      r_s2dly[0] <= bus.S2;
      for (int i = 1; i < 16; i++) r_s2dly[i] <= r_s2dly[i-1];
    end
  end

  logic [7:0]  w_pe_r  [0:15];
  logic [7:0]  w_pe_s  [0:15];
  logic [7:0]  w_pe_ad [0:15];
  logic [15:0] r_acc   [0:15];

  // PE k handles dx=k-8. While the delayed R sample's column plus k stays in
  // the left 16 columns it lines up with the current S1 pixel; once it wraps
  // past, the needed pixel was fetched as S2 one block row (16 cycles) ago.
  generate
    for (genvar k = 0; k < 16; k++) begin : g_pe
      if (k == 0) begin : g_head
        assign w_pe_r[k] = bus.R;
        assign w_pe_s[k] = bus.S1;
      end else begin : g_tail
        assign w_pe_r[k] = r_rdly[k];
        assign w_pe_s[k] = (w_col >= 4'(k)) ? bus.S1 : r_s2dly[15];
      end
      assign w_pe_ad[k] = (w_pe_r[k] >= w_pe_s[k]) ? (w_pe_r[k] - w_pe_s[k])
                                                   : (w_pe_s[k] - w_pe_r[k]);
    end
  endgenerate

  // PE k sees the first pixel of a candidate row when count[7:0]==k and
  // restarts its sum there; the previous sum is read by the comparator on
  // that same edge.
  always_ff @(posedge clock) begin
    if (!w_run) begin
      for (int i = 0; i < 16; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_count[7:0] == 8'(i)) begin
          r_acc[i] <= {8'd0, w_pe_ad[i]};
        end else begin
          r_acc[i] <= r_acc[i] + {8'd0, w_pe_ad[i]};
        end
      end
    end
  end

  // Finished SAD of PE k (candidate row vy) sits in r_acc[k] while
  // count = (vy+1)*256 + k; count 4096..4111 wraps vy back to 15.
  logic        w_cmp_valid;
  logic [15:0] w_cmp_sad;
  logic [3:0]  w_cmp_vy;
  logic [15:0] r_best;
  logic [3:0]  r_mx;
  logic [3:0]  r_my;

  assign w_cmp_valid = (r_count >= c_first_cmp) && (r_count <= c_last_cmp) &&
                       (r_count[7:4] == 4'd0);
  assign w_cmp_sad   = r_acc[r_count[3:0]];
  assign w_cmp_vy    = r_count[11:8] - 4'd1;

  // Results hold while start is low; only a fresh run reinitialises them.
  // Strict less-than keeps the earliest candidate in scan order on ties.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_best <= 16'hFFFF;
      r_mx   <= '0;
      r_my   <= '0;
    end else if (bus.start) begin
      if (r_count == '0) begin
        r_best <= 16'hFFFF;
        r_mx   <= '0;
        r_my   <= '0;
      end else if (w_cmp_valid && (w_cmp_sad < r_best)) begin
        r_best <= w_cmp_sad;
        r_mx   <= {~r_count[3], r_count[2:0]};   // k-8 in 4-bit two's complement
        r_my   <= {~w_cmp_vy[3], w_cmp_vy[2:0]}; // vy-8
      end
    end
  end

  assign bus.motionX   = r_mx;
  assign bus.motionY   = r_my;
  assign bus.BestDist  = (r_best > 16'd255) ? 8'hFF : r_best[7:0];
  assign bus.completed = (r_count == c_count_done);

endmodule
`default_nettype wire

// File: tb/tb_motion_estimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_motion_estimator                                           |
// | Purpose  : Self-checking bench for motion_estimator. Frame memories are  |
// |            modelled as combinational arrays; expected results come from  |
// |            a scenario table or a direct full-search model and flow       |
// |            through a scoreboard queue.                                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_motion_estimator;

  localparam int M_RAND_MATCH = 0;
  localparam int M_ZERO       = 1;
  localparam int M_FF00       = 2;
  localparam int M_PERIODIC   = 3;
  localparam int M_RAND_ALL   = 4;
  localparam int N_VECS       = 9;

  typedef struct {
    int mode;
    int dx;
    int dy;
    int npert;
    int amt;
    bit use_model;
    int ebest;
    int edx;
    int edy;
  } vec_t;

  typedef struct {
    int         best;
    logic [3:0] mx;
    logic [3:0] my;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  motion_estimator_if bus ();

  motion_estimator dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem_r [0:255];
  logic [7:0] mem_s [0:1023];

  assign bus.R  = mem_r[bus.AddressR];
  assign bus.S1 = mem_s[bus.AddressS1];
  assign bus.S2 = mem_s[bus.AddressS2];

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [0:N_VECS-1];
  vec_t vz;
  vec_t vm;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    logic [7:0] pat [0:127];
    int idx;
    for (int i = 0; i < 1024; i++) mem_s[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) mem_r[i] = 8'($urandom_range(0, 255));
    if (v.mode == M_ZERO) begin
      for (int i = 0; i < 1024; i++) mem_s[i] = 8'h00;
      for (int i = 0; i < 256; i++) mem_r[i] = 8'h00;
    end else if (v.mode == M_FF00) begin
      for (int i = 0; i < 1024; i++) mem_s[i] = 8'h00;
      for (int i = 0; i < 256; i++) mem_r[i] = 8'hFF;
    end else if (v.mode == M_PERIODIC) begin
      // Every row repeats with period 4 horizontally
      for (int i = 0; i < 128; i++) pat[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 1024; i++) mem_s[i] = pat[(i / 32) * 4 + (i % 4)];
    end
    if (v.mode == M_RAND_MATCH || v.mode == M_PERIODIC) begin
      for (int i = 0; i < 256; i++)
        mem_r[i] = mem_s[((i / 16) + 8 + v.dy) * 32 + (i % 16) + 8 + v.dx];
    end
    for (int p = 0; p < v.npert; p++) begin
      idx = (p * 37 + 5) % 256;
      if (mem_r[idx] >= 8'd128) mem_r[idx] = mem_r[idx] - 8'(v.amt);
      else                      mem_r[idx] = mem_r[idx] + 8'(v.amt);
    end
  endtask

  // Direct full search straight from the definition of a candidate.
  task automatic model(output int best, output logic [3:0] mx, output logic [3:0] my);
    int sad;
    int d;
    best = 65535;
    mx   = 4'd0;
    my   = 4'd0;
    for (int vy = 0; vy < 16; vy++) begin
      for (int k = 0; k < 16; k++) begin
        sad = 0;
        for (int i = 0; i < 256; i++) begin
          d = int'(mem_r[i]) - int'(mem_s[((i / 16) + vy) * 32 + (i % 16) + k]);
          sad += (d < 0) ? -d : d;
        end
        if (sad < best) begin
          best = sad;
          mx   = 4'(k - 8);
          my   = 4'(vy - 8);
        end
      end
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    int   b;
    if (v.use_model) begin
      model(b, e.mx, e.my);
      e.best = (b > 255) ? 255 : b;
    end else begin
      e.best = v.ebest;
      e.mx   = 4'(v.edx);
      e.my   = 4'(v.edy);
    end
    sb.push_back(e);
  endtask

  // Called on a negedge with count=0; leaves start low and count back at 0.
  task automatic run_and_check(input string tag);
    int   cyc;
    exp_t e;
    bus.start = 1'b1;
    cyc = 0;
    while (!bus.completed && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, " latency"}, cyc, 4112);
    if (sb.size() == 0) begin
      check({tag, " scoreboard-empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, " BestDist"}, int'(bus.BestDist), e.best);
      check({tag, " motionX"}, int'(bus.motionX), int'(e.mx));
      check({tag, " motionY"}, int'(bus.motionY), int'(e.my));
      repeat (3) @(negedge clock);
      check({tag, " completed-hold"}, int'(bus.completed), 1);
      bus.start = 1'b0;
      @(negedge clock);
      check({tag, " completed-clear"}, int'(bus.completed), 0);
      check({tag, " motionX-held"}, int'(bus.motionX), int'(e.mx));
      check({tag, " BestDist-held"}, int'(bus.BestDist), e.best);
    end
    bus.start = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    //           mode          dx  dy  np  amt  mdl best  edx edy
    vecs[0] = '{M_RAND_MATCH,  3, -5, 0,   0, 1'b0,   0,  3, -5};
    vecs[1] = '{M_ZERO,        0,  0, 0,   0, 1'b0,   0, -8, -8};
    vecs[2] = '{M_FF00,        0,  0, 0,   0, 1'b0, 255, -8, -8};
    vecs[3] = '{M_RAND_MATCH, -8,  7, 0,   0, 1'b0,   0, -8,  7};
    vecs[4] = '{M_PERIODIC,    3, -5, 0,   0, 1'b0,   0, -5, -5};
    vecs[5] = '{M_RAND_MATCH, -2,  4, 7,   1, 1'b0,   7, -2,  4};
    vecs[6] = '{M_RAND_MATCH,  5, -8, 2, 127, 1'b0, 254,  5, -8};
    vecs[7] = '{M_RAND_MATCH,  7,  0, 3,  85, 1'b0, 255,  7,  0};
    vecs[8] = '{M_RAND_ALL,    0,  0, 0,   0, 1'b1,   0,  0,  0};
    vz      = '{M_ZERO,        0,  0, 0,   0, 1'b0,   0, -8, -8};
    vm      = '{M_RAND_MATCH,  3, -5, 0,   0, 1'b0,   0,  3, -5};

    reset     = 1'b0;
    bus.start = 1'b0;
    load(vz);
    repeat (3) @(negedge clock);
    check("reset BestDist", int'(bus.BestDist), 255);
    check("reset motionX", int'(bus.motionX), 0);
    check("reset motionY", int'(bus.motionY), 0);
    check("reset completed", int'(bus.completed), 0);
    check("reset AddressR", int'(bus.AddressR), 0);
    check("reset AddressS1", int'(bus.AddressS1), 0);
    reset = 1'b1;
    @(negedge clock);

    // Address decode at count 0x1A5 (vy=1, r=10, c=5)
    bus.start = 1'b1;
    repeat (421) @(negedge clock);
    check("addr AddressR", int'(bus.AddressR), 'hA5);
    check("addr AddressS1", int'(bus.AddressS1), 357);
    check("addr AddressS2", int'(bus.AddressS2), 373);
    bus.start = 1'b0;
    @(negedge clock);

    for (int i = 0; i < N_VECS; i++) begin
      load(vecs[i]);
      push_exp(vecs[i]);
      run_and_check($sformatf("vec%0d", i));
    end

    // Reset in the middle of a run, then a full rerun
    load(vm);
    bus.start = 1'b1;
    repeat (2000) @(negedge clock);
    check("midrst pre BestDist", int'(bus.BestDist), 0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst BestDist", int'(bus.BestDist), 255);
    check("midrst motionX", int'(bus.motionX), 0);
    check("midrst motionY", int'(bus.motionY), 0);
    check("midrst completed", int'(bus.completed), 0);
    check("midrst AddressR", int'(bus.AddressR), 0);
    reset = 1'b1;
    push_exp(vm);
    run_and_check("rerun-after-reset");

    // start dropped mid-run: partial result held, count and completed cleared
    bus.start = 1'b1;
    repeat (2000) @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    check("drop completed", int'(bus.completed), 0);
    check("drop AddressR", int'(bus.AddressR), 0);
    check("drop AddressS1", int'(bus.AddressS1), 0);
    check("drop BestDist-held", int'(bus.BestDist), 0);
    check("drop motionX-held", int'(bus.motionX), 3);
    check("drop motionY-held", int'(bus.motionY), 11);
    bus.start = 1'b1;
    @(negedge clock);
    check("newrun BestDist", int'(bus.BestDist), 255);
    check("newrun motionX", int'(bus.motionX), 0);
    check("newrun motionY", int'(bus.motionY), 0);
    bus.start = 1'b0;
    @(negedge clock);
    push_exp(vm);
    run_and_check("rerun-after-drop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
